// File: rtl/pipes.sv
// Shared pipeline types: data word, decoded op encoding, divider state and iteration counts.
// Also holds small decode helpers used by the divider.
package pipes;

    typedef logic [63:0] word_t;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU,
        OP_DIVW,
        OP_DIVUW,
        OP_REMW,
        OP_REMUW
    } decoded_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } div_state_t;

    typedef logic [6:0] div_cnt_t;

    localparam div_cnt_t DIV_ITER_64 = 7'd64;
    localparam div_cnt_t DIV_ITER_32 = 7'd32;

    function automatic logic is_div_op(input decoded_op_t op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU,
            OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_w_op(input decoded_op_t op);
        case (op)
            OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op(input decoded_op_t op);
        case (op)
            OP_DIV, OP_REM, OP_DIVW, OP_REMW: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_rem_op(input decoded_op_t op);
        case (op)
            OP_REM, OP_REMU, OP_REMW, OP_REMUW: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic word_t sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/div_fixup.sv
// Divider operand prep, special-case results and final sign correction.
// Latency: purely combinational.
// Backpressure: none; consumers sample the outputs when they need them.
module div_fixup
    import pipes::*;
(
    input  decoded_op_t op,
    input  word_t       srca,
    input  word_t       srcb,
    output word_t       mag_a,
    output word_t       mag_b,
    output logic        neg_res,
    output logic        special,
    output word_t       special_result,
    input  decoded_op_t fin_op,
    input  logic        fin_neg,
    input  word_t       fin_quo,
    input  word_t       fin_rem,
    output word_t       fin_result
);

    logic  is_w;
    logic  sgn;
    logic  rem;
    logic  neg_a;
    logic  neg_b;
    logic  div_zero;
    logic  ovf;
    word_t ext_a;
    word_t ext_b;
    word_t most_neg;
    word_t spec_val;
    word_t fin_val;
    word_t fin_signed;

    always_comb begin
        is_w = is_w_op(op);
        sgn  = is_signed_op(op);
        rem  = is_rem_op(op);

        ext_a = is_w ? (sgn ? sext32(srca[31:0]) : {32'b0, srca[31:0]}) : srca;
        ext_b = is_w ? (sgn ? sext32(srcb[31:0]) : {32'b0, srcb[31:0]}) : srcb;

        // Operands are already sign-extended to 64 bits, so bit 63 is the sign for both widths.
        neg_a = sgn & ext_a[63];
        neg_b = sgn & ext_b[63];
        mag_a = neg_a ? -ext_a : ext_a;
        mag_b = neg_b ? -ext_b : ext_b;

        div_zero = (ext_b == '0);
        most_neg = is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        ovf      = sgn & (ext_a == most_neg) & (ext_b == '1);
        special  = div_zero | ovf;
        neg_res  = rem ? neg_a : (neg_a ^ neg_b);

        if (div_zero) begin
            spec_val = rem ? ext_a : '1;
        end else begin
            spec_val = rem ? '0 : ext_a;
        end
        special_result = is_w ? sext32(spec_val[31:0]) : spec_val;
    end

    always_comb begin
        fin_val    = is_rem_op(fin_op) ? fin_rem : fin_quo;
        fin_signed = fin_neg ? -fin_val : fin_val;
        fin_result = is_w_op(fin_op) ? sext32(fin_signed[31:0]) : fin_signed;
    end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring integer divider for the execute stage (RV64 M-extension div/rem ops).
// Latency: 65 cycles for 64-bit ops, 33 for W ops, 1 for divide-by-zero / signed overflow.
// Backpressure: busy stalls execute; valid outside IDLE is dropped, flush/reset abort at once.
module div_unit
    import pipes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  decoded_op_t op,
    input  word_t       srca,
    input  word_t       srcb,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output word_t       result
);

    div_state_t  state;
    div_state_t  next_state;
    div_cnt_t    cnt;
    word_t       quo;
    word_t       rem;
    word_t       dvsr;
    decoded_op_t lat_op;
    logic        lat_neg;

    word_t       mag_a;
    word_t       mag_b;
    logic        neg_res;
    logic        special;
    word_t       special_result;
    word_t       fin_result;

    logic        start;
    logic        last_step;
    logic [64:0] shifted;
    logic        ge;
    word_t       diff;
    word_t       step_rem;
    word_t       step_quo;

    div_fixup u_fixup (
        .op             (op),
        .srca           (srca),
        .srcb           (srcb),
        .mag_a          (mag_a),
        .mag_b          (mag_b),
        .neg_res        (neg_res),
        .special        (special),
        .special_result (special_result),
        .fin_op         (lat_op),
        .fin_neg        (lat_neg),
        .fin_quo        (step_quo),
        .fin_rem        (step_rem),
        .fin_result     (fin_result)
    );

    assign start     = valid & ~flush & is_div_op(op);
    assign last_step = (cnt == 7'd1);

    // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
    always_comb begin
        shifted  = {rem, quo[63]};
        ge       = (shifted >= {1'b0, dvsr});
        diff     = shifted[63:0] - dvsr;
        step_rem = ge ? diff : shifted[63:0];
        step_quo = {quo[62:0], ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = special ? FINISH : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    next_state = FINISH;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == FINISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
            lat_op  <= OP_NOP;
            lat_neg <= 1'b0;
            result  <= '0;
        end else if (state == IDLE && start) begin
            lat_op  <= op;
            lat_neg <= neg_res;
            rem     <= '0;
            dvsr    <= mag_b;
            // W dividends sit in the top half so the quotient bits always shift out of bit 63.
            quo     <= is_w_op(op) ? {mag_a[31:0], 32'b0} : mag_a;
            cnt     <= is_w_op(op) ? DIV_ITER_32 : DIV_ITER_64;
            if (special) begin
                result <= special_result;
            end
        end else if (state == RUN && !flush) begin
            rem <= step_rem;
            quo <= step_quo;
            cnt <= cnt - 7'd1;
            if (last_step) begin
                result <= fin_result;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors push expected result and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_div_unit;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        flush;
    decoded_op_t op;
    word_t       srca;
    word_t       srcb;
    logic        busy;
    logic        done;
    word_t       result;

    div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid),
        .op     (op),
        .srca   (srca),
        .srcb   (srcb),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks     = 0;
    int errors     = 0;
    int done_count = 0;

    word_t exp_res_q[$];
    int    exp_cyc_q[$];
    string exp_name_q[$];

    localparam word_t NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam word_t NEG3 = 64'hFFFF_FFFF_FFFF_FFFD;

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        string n;
        word_t r;
        int    c;
        if (!reset && done) begin
            done_count++;
            if (exp_res_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done at cycle %0d result %h, expected no done", cyc, result);
            end else begin
                n = exp_name_q.pop_front();
                r = exp_res_q.pop_front();
                c = exp_cyc_q.pop_front();
                check({n, "_result"}, result, r);
                check({n, "_cycle"}, 64'(cyc), 64'(c));
                check({n, "_busy_at_done"}, {63'b0, busy}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input decoded_op_t o, input word_t a, input word_t b,
                         input word_t exp, input int lat, input bit push, input string name);
        op    = o;
        srca  = a;
        srcb  = b;
        valid = 1'b1;
        if (push) begin
            exp_res_q.push_back(exp);
            exp_cyc_q.push_back(cyc + lat);
            exp_name_q.push_back(name);
        end
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && exp_res_q.size() != 0; i++) begin
            tick();
        end
        if (exp_res_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d expected done pulses outstanding, required 0", exp_res_q.size());
            exp_res_q.delete();
            exp_cyc_q.delete();
            exp_name_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc0;
        reset = 1'b1;
        valid = 1'b0;
        flush = 1'b0;
        op    = OP_NOP;
        srca  = '0;
        srcb  = '0;
        repeat (3) tick();
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        reset = 1'b0;
        tick();

        // Signed 64-bit divide and remainder with a negative divisor.
        issue(OP_DIV, 64'd20, NEG3, 64'hFFFF_FFFF_FFFF_FFFA, 65, 1'b1, "div_20_m3");
        repeat (3) tick();
        check("div_busy_in_run", {63'b0, busy}, 64'd1);
        wait_done(100);
        issue(OP_REM, 64'd20, NEG3, 64'd2, 65, 1'b1, "rem_20_m3");
        wait_done(100);

        // Divide by zero and signed overflow finish in one cycle.
        issue(OP_DIVU, 64'd7, 64'd0, NEG1, 1, 1'b1, "divu_7_0");
        wait_done(10);
        issue(OP_REMU, 64'd7, 64'd0, 64'd7, 1, 1'b1, "remu_7_0");
        wait_done(10);
        issue(OP_DIV, 64'h8000_0000_0000_0000, NEG1, 64'h8000_0000_0000_0000, 1, 1'b1, "div_ovf");
        wait_done(10);
        issue(OP_REM, 64'h8000_0000_0000_0000, NEG1, 64'd0, 1, 1'b1, "rem_ovf");
        wait_done(10);

        // W ops.
        issue(OP_DIVW, 64'h1_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, 1'b1, "divw");
        wait_done(60);
        issue(OP_REMUW, 64'hFFFF_FFFF, 64'd10, 64'd5, 33, 1'b1, "remuw");
        wait_done(60);

        // Non-divide op is ignored; b=0 would look like a special case if it were decoded.
        issue(OP_ADD, 64'd1, 64'd0, 64'd0, 0, 1'b0, "add");
        check("nondiv_busy", {63'b0, busy}, 64'd0);
        check("nondiv_done", {63'b0, done}, 64'd0);
        issue(OP_MUL, 64'd6, 64'd3, 64'd0, 0, 1'b0, "mul");
        repeat (70) tick();
        check("nondiv_result_kept", result, 64'd5);

        // Flush at cycle 10, new DIVU at cycle 12 completes at cycle 77.
        issue(OP_DIV, 64'd1000, 64'd3, 64'd0, 0, 1'b0, "div_flushed");
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {63'b0, busy}, 64'd0);
        check("flush_done", {63'b0, done}, 64'd0);
        check("flush_result_kept", result, 64'd5);
        tick();
        issue(OP_DIVU, 64'd100, 64'd7, 64'd14, 65, 1'b1, "divu_100_7");
        wait_done(100);

        // Flush coincident with valid in IDLE: nothing starts.
        flush = 1'b1;
        issue(OP_DIVU, 64'd7, 64'd0, 64'd0, 0, 1'b0, "flush_special");
        check("flush_valid_special_done", {63'b0, done}, 64'd0);
        issue(OP_DIV, 64'd20, NEG3, 64'd0, 0, 1'b0, "flush_div");
        flush = 1'b0;
        check("flush_valid_busy", {63'b0, busy}, 64'd0);
        repeat (70) tick();
        check("flush_valid_result_kept", result, 64'd14);

        // Back to back with stray valids in RUN and FINISH.
        dc0 = done_count;
        issue(OP_DIVU, 64'd9, 64'd2, 64'd4, 65, 1'b1, "divu_9_2");
        repeat (4) tick();
        issue(OP_DIVU, 64'd1, 64'd1, 64'd0, 0, 1'b0, "stray_run1");
        repeat (14) tick();
        issue(OP_DIVU, 64'd1, 64'd0, 64'd0, 0, 1'b0, "stray_run2");
        repeat (44) tick();
        check("b2b_done_first", {63'b0, done}, 64'd1);
        issue(OP_DIVU, 64'd1, 64'd0, 64'd0, 0, 1'b0, "stray_finish");
        issue(OP_REMU, 64'd9, 64'd2, 64'd1, 65, 1'b1, "remu_9_2");
        wait_done(100);
        tick();
        check("b2b_done_count", 64'(done_count - dc0), 64'd2);

        // Reset mid-RUN aborts without a done pulse and clears result.
        issue(OP_DIV, 64'd50, 64'd5, 64'd0, 0, 1'b0, "div_reset");
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_busy", {63'b0, busy}, 64'd0);
        check("midreset_done", {63'b0, done}, 64'd0);
        check("midreset_result", result, 64'd0);
        repeat (70) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
